// File: rtl/imem_pkg.sv
// Shared types for the instruction-memory port controller.
// FSM encoding, word beat count and round-robin pointer.
package imem_pkg;

  localparam int IMEM_BEATS = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_RESP,
    S_WRITE
  } state_t;

  typedef enum logic {
    RR_LOAD,
    RR_FETCH
  } rr_t;

endpackage

// File: rtl/imem_port_ctrl_if.sv
// Bundle of fetch, loader and memory-side signals.
// slave = controller view, master = environment view.
interface imem_port_ctrl_if;

  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_gnt;
  logic        fetch_rsp_valid;
  logic        fetch_rsp_ready;
  logic [31:0] fetch_rsp_data;
  logic        fetch_rsp_err;

  logic        load_req;
  logic [31:0] load_addr;
  logic [7:0]  load_wdata;
  logic        load_ack;

  logic [31:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  modport slave (
    input  fetch_req,
    input  fetch_addr,
    input  fetch_rsp_ready,
    input  load_req,
    input  load_addr,
    input  load_wdata,
    input  mem_rdata,
    output fetch_gnt,
    output fetch_rsp_valid,
    output fetch_rsp_data,
    output fetch_rsp_err,
    output load_ack,
    output mem_addr,
    output mem_we,
    output mem_wdata
  );

  modport master (
    output fetch_req,
    output fetch_addr,
    output fetch_rsp_ready,
    output load_req,
    output load_addr,
    output load_wdata,
    output mem_rdata,
    input  fetch_gnt,
    input  fetch_rsp_valid,
    input  fetch_rsp_data,
    input  fetch_rsp_err,
    input  load_ack,
    input  mem_addr,
    input  mem_we,
    input  mem_wdata
  );

endinterface

// File: rtl/imem_addr_check.sv
// Combinational alignment / range check for a SPAN-byte access.
// The 33-bit sum keeps addresses near 2^32 from wrapping in range.
module imem_addr_check #(
  parameter int ENTRIES = 128,
  parameter int SPAN    = 4
) (
  input  logic [31:0] addr,
  output logic        err
);

  logic [32:0] last;
  logic [1:0]  mask;
  logic        misal;
  logic        oor;

  assign mask  = 2'(SPAN - 1);
  assign last  = {1'b0, addr} + 33'(SPAN - 1);
  assign misal = |(addr[1:0] & mask);
  assign oor   = last >= 33'(ENTRIES);
  assign err   = misal | oor;

endmodule

// File: rtl/imem_port_ctrl.sv
// Single-port imem arbiter: big-endian word fetch vs loader byte write.
// Fetch grant is a registered pulse; the address is captured on its rising edge.
module imem_port_ctrl
  import imem_pkg::*;
#(
  parameter int ENTRIES = 128,
  parameter int BEATS   = IMEM_BEATS
) (
  input logic              clk,
  input logic              rst_n,
  imem_port_ctrl_if.slave  bus
);

  localparam logic [1:0] LAST = 2'(BEATS - 1);

  state_t      state_q;
  rr_t         rr_q;
  logic [1:0]  beat_q;
  logic [31:0] base_q;
  logic        bad_q;
  logic [31:0] word_q;
  logic        gnt_q;
  logic        valid_q;
  logic        err_q;
  logic        ack_q;
  logic        we_q;
  logic [31:0] maddr_q;
  logic [7:0]  wdata_q;

  logic fetch_bad;
  logic load_bad;
  logic pick_load;
  logic pick_fetch;

  imem_addr_check #(
    .ENTRIES (ENTRIES),
    .SPAN    (BEATS)
  ) u_fchk (
    .addr (bus.fetch_addr),
    .err  (fetch_bad)
  );

  imem_addr_check #(
    .ENTRIES (ENTRIES),
    .SPAN    (1)
  ) u_lchk (
    .addr (bus.load_addr),
    .err  (load_bad)
  );

  assign pick_load  = bus.load_req &
                      (~bus.fetch_req | (rr_q == RR_LOAD));
  assign pick_fetch = bus.fetch_req & ~pick_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rr_q    <= RR_LOAD;
      beat_q  <= '0;
      base_q  <= '0;
      bad_q   <= 1'b0;
      word_q  <= '0;
      gnt_q   <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      ack_q   <= 1'b0;
      we_q    <= 1'b0;
      maddr_q <= '0;
      wdata_q <= '0;
    end else begin
      gnt_q   <= 1'b0;
      ack_q   <= 1'b0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      unique case (state_q)
        S_IDLE: begin
          if (gnt_q) begin
            beat_q <= '0;
            word_q <= '0;
            if (bad_q) begin
              state_q <= S_RESP;
              valid_q <= 1'b1;
              err_q   <= 1'b1;
            end else begin
              state_q <= S_READ;
              maddr_q <= base_q;
            end
          end else if (pick_load) begin
            state_q <= S_WRITE;
            ack_q   <= 1'b1;
            we_q    <= ~load_bad;
            maddr_q <= bus.load_addr;
            wdata_q <= bus.load_wdata;
            rr_q    <= RR_FETCH;
          end else if (pick_fetch) begin
            gnt_q  <= 1'b1;
            base_q <= bus.fetch_addr;
            bad_q  <= fetch_bad;
            rr_q   <= RR_LOAD;
          end
        end
        S_READ: begin
          word_q <= {word_q[23:0], bus.mem_rdata};
          beat_q <= beat_q + 2'd1;
          if (beat_q == LAST) begin
            state_q <= S_RESP;
            valid_q <= 1'b1;
            maddr_q <= '0;
          end else begin
            maddr_q <= maddr_q + 32'd1;
          end
        end
        S_RESP: begin
          if (bus.fetch_rsp_ready) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            word_q  <= '0;
          end
        end
        S_WRITE: begin
          state_q <= S_IDLE;
          maddr_q <= '0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.fetch_gnt       = gnt_q;
  assign bus.fetch_rsp_valid = valid_q;
  assign bus.fetch_rsp_data  = word_q;
  assign bus.fetch_rsp_err   = err_q;
  assign bus.load_ack        = ack_q;
  assign bus.mem_addr        = maddr_q;
  assign bus.mem_we          = we_q;
  assign bus.mem_wdata       = wdata_q;

endmodule
